// File: rtl/shader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shader_pkg
// Description : Shared constants and types for the shader sequencer slice:
//               default program geometry, the no-operation opcode used to
//               fill program storage on reset, and the sequencer state enum.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package shader_pkg;

    // Default number of program words per pixel (power of two, >= 2)
    localparam int SHADER_NUM_INSTR   = 8;
    // Default instruction word width in bits
    localparam int SHADER_INSTR_WIDTH = 8;
    // Opcode the execute stage performs as no operation
    localparam logic [7:0] NOP_INSTR  = 8'h30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage : shader_pkg
`default_nettype wire

// File: rtl/shader_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : shader_sequencer_if
// Description : Bundles the program-load handshake, pixel trigger and issue
//               outputs of the shader sequencer. Signal suffixes are written
//               from the sequencer's point of view.
// Ports       : load_start_i, load_valid_i, load_data_i, load_ready_o,
//               pixel_start_i, instr_o, execute_o, done_o, overrun_o
//               slave  modport - the sequencer
//               master modport - the program loader / pixel pipeline
// Revision    : 1.0 - initial release
// ============================================================================
interface shader_sequencer_if #(
    parameter int INSTR_WIDTH = shader_pkg::SHADER_INSTR_WIDTH
);
    logic                   load_start_i;
    logic                   load_valid_i;
    logic [INSTR_WIDTH-1:0] load_data_i;
    logic                   load_ready_o;
    logic                   pixel_start_i;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic                   execute_o;
    logic                   done_o;
    logic                   overrun_o;

    modport slave (
        input  load_start_i,
        input  load_valid_i,
        input  load_data_i,
        input  pixel_start_i,
        output load_ready_o,
        output instr_o,
        output execute_o,
        output done_o,
        output overrun_o
    );

    modport master (
        output load_start_i,
        output load_valid_i,
        output load_data_i,
        output pixel_start_i,
        input  load_ready_o,
        input  instr_o,
        input  execute_o,
        input  done_o,
        input  overrun_o
    );

endinterface : shader_sequencer_if
`default_nettype wire

// File: rtl/shader_memory.sv
`default_nettype none
// ============================================================================
// Module      : shader_memory
// Description : Program storage for the shader sequencer. Register array with
//               one synchronous write port and one asynchronous read port.
//               Every word is filled with the NOP opcode on reset.
// Ports       : clk_i   - clock
//               rst_ni  - synchronous active-low reset (NOP fill)
//               we_i    - write enable
//               waddr_i - write address
//               wdata_i - write data
//               raddr_i - read address
//               rdata_o - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module shader_memory
    import shader_pkg::*;
#(
    parameter int NUM_INSTR   = SHADER_NUM_INSTR,
    parameter int INSTR_WIDTH = SHADER_INSTR_WIDTH,
    parameter int ADDR_WIDTH  = $clog2(NUM_INSTR)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [ADDR_WIDTH-1:0]  waddr_i,
    input  logic [INSTR_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0]  raddr_i,
    output logic [INSTR_WIDTH-1:0] rdata_o
);

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(NOP_INSTR);

    logic [INSTR_WIDTH-1:0] mem_q [NUM_INSTR];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_INSTR; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // NUM_INSTR is a power of two, so every address value maps to a word
    assign rdata_o = mem_q[raddr_i];

endmodule : shader_memory
`default_nettype wire

// File: rtl/shader_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shader_sequencer
// Description : Per-pixel instruction sequencer. A program of NUM_INSTR words
//               is loaded through a valid/ready handshake and then issued,
//               one word per cycle, after each pixel_start pulse. A done pulse
//               follows the last issue; a pixel_start arriving mid-run sets a
//               sticky overrun flag.
// Ports       : clk_i  - clock, all logic rising-edge
//               rst_ni - synchronous active-low reset
//               bus_if - shader_sequencer_if.slave (load handshake, pixel
//                        trigger, instruction issue, done, overrun)
// Revision    : 1.0 - initial release
// ============================================================================
module shader_sequencer
    import shader_pkg::*;
#(
    parameter int NUM_INSTR   = SHADER_NUM_INSTR,
    // Must match the width the connected interface was built with
    parameter int INSTR_WIDTH = SHADER_INSTR_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    shader_sequencer_if.slave   bus_if
);

    localparam int                     AW       = $clog2(NUM_INSTR);
    localparam logic [AW-1:0]          LAST_IDX = AW'(NUM_INSTR - 1);
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(NOP_INSTR);

    state_e                 state_q,   state_d;
    logic [AW-1:0]          pc_q,      pc_d;
    logic [AW-1:0]          wptr_q,    wptr_d;
    logic [INSTR_WIDTH-1:0] instr_q,   instr_d;
    logic                   execute_q, execute_d;
    logic                   done_q,    done_d;
    logic                   overrun_q, overrun_d;

    logic                   mem_we;
    logic [AW-1:0]          mem_raddr;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    shader_memory #(
        .NUM_INSTR   (NUM_INSTR),
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH  (AW)
    ) u_memory (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (mem_we),
        .waddr_i (wptr_q),
        .wdata_i (bus_if.load_data_i),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // The read port always looks one word ahead of the issue register: word 0
    // while waiting for a pixel, word pc+1 while running. Issue output is
    // therefore registered with no extra pipeline stage.
    assign mem_raddr = (state_q == RUN) ? (pc_q + AW'(1)) : '0;

    // A restart request takes priority over a word presented in the same cycle
    assign mem_we = (state_q == LOAD) && bus_if.load_valid_i && !bus_if.load_start_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            wptr_q    <= '0;
            instr_q   <= NOP_WORD;
            execute_q <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wptr_q    <= wptr_d;
            instr_q   <= instr_d;
            execute_q <= execute_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wptr_d    = wptr_q;
        instr_d   = instr_q;
        execute_d = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (bus_if.load_start_i) begin
                    // Load wins over a coincident pixel_start
                    state_d   = LOAD;
                    wptr_d    = '0;
                    overrun_d = 1'b0;
                end else if (bus_if.pixel_start_i) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    instr_d   = mem_rdata;
                    execute_d = 1'b1;
                end
            end

            LOAD: begin
                // pixel_start is ignored here and never flags an overrun
                if (bus_if.load_start_i) begin
                    wptr_d    = '0;
                    overrun_d = 1'b0;
                end else if (bus_if.load_valid_i) begin
                    wptr_d = wptr_q + AW'(1);
                    if (wptr_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end

            RUN: begin
                if (bus_if.load_start_i) begin
                    // Abort: no further issue and no done pulse
                    state_d   = LOAD;
                    wptr_d    = '0;
                    overrun_d = 1'b0;
                end else begin
                    if (bus_if.pixel_start_i) begin
                        overrun_d = 1'b1;
                    end
                    if (pc_q == LAST_IDX) begin
                        // Done cycle is spent in IDLE so a coincident
                        // pixel_start is taken as the next run
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pc_d      = pc_q + AW'(1);
                        instr_d   = mem_rdata;
                        execute_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_if.load_ready_o = (state_q == LOAD);
    assign bus_if.instr_o      = instr_q;
    assign bus_if.execute_o    = execute_q;
    assign bus_if.done_o       = done_q;
    assign bus_if.overrun_o    = overrun_q;

endmodule : shader_sequencer
`default_nettype wire

// File: tb/tb_shader_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shader_sequencer
// Description : Directed self-checking bench for shader_sequencer. Inputs
//               change 1 ns after each rising edge; outputs are checked in the
//               same window, so each step() advances exactly one clock cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shader_sequencer;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    logic [7:0] prog1 [8];
    logic [7:0] prog2 [8];

    shader_sequencer_if #(.INSTR_WIDTH(8)) bus ();

    shader_sequencer #(
        .NUM_INSTR   (8),
        .INSTR_WIDTH (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_exec"}, 32'(bus.execute_o), 32'd0);
        chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        prog1 = '{8'hC5, 8'h10, 8'h04, 8'hA7, 8'h5E, 8'h81, 8'hFF, 8'h03};
        prog2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        rst_n             = 1'b0;
        bus.load_start_i  = 1'b0;
        bus.load_valid_i  = 1'b0;
        bus.load_data_i   = 8'h00;
        bus.pixel_start_i = 1'b0;
        step();
        step();

        // ---- reset state
        chk("rst_instr",   32'(bus.instr_o), 32'h30);
        chk("rst_exec",    32'(bus.execute_o), 32'd0);
        chk("rst_done",    32'(bus.done_o), 32'd0);
        chk("rst_overrun", 32'(bus.overrun_o), 32'd0);
        chk("rst_ready",   32'(bus.load_ready_o), 32'd0);
        rst_n = 1'b1;
        step();

        // ---- run of the reset (all-NOP) program
        bus.pixel_start_i = 1'b1;
        step();
        bus.pixel_start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("nop_exec",  32'(bus.execute_o), 32'd1);
            chk("nop_instr", 32'(bus.instr_o), 32'h30);
            step();
        end
        chk("nop_done_exec", 32'(bus.execute_o), 32'd0);
        chk("nop_done",      32'(bus.done_o), 32'd1);
        step();
        chk("nop_done_once", 32'(bus.done_o), 32'd0);

        // ---- load prog1 with valid on alternate cycles
        bus.load_start_i = 1'b1;
        step();
        bus.load_start_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("load_ready", 32'(bus.load_ready_o), 32'd1);
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = prog1[i];
            step();
            bus.load_valid_i = 1'b0;
            if (i < 7) begin
                chk("load_ready_gap", 32'(bus.load_ready_o), 32'd1);
                step();
            end
        end
        chk("load_ready_end", 32'(bus.load_ready_o), 32'd0);
        chk("load_exec",      32'(bus.execute_o), 32'd0);

        // ---- run prog1, then back-to-back second run on the done cycle
        bus.pixel_start_i = 1'b1;
        step();
        bus.pixel_start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("p1_exec",  32'(bus.execute_o), 32'd1);
            chk("p1_instr", 32'(bus.instr_o), 32'(prog1[k]));
            step();
        end
        chk("p1_done",      32'(bus.done_o), 32'd1);
        chk("p1_done_exec", 32'(bus.execute_o), 32'd0);
        bus.pixel_start_i = 1'b1;
        step();
        bus.pixel_start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("b2b_exec",  32'(bus.execute_o), 32'd1);
            chk("b2b_instr", 32'(bus.instr_o), 32'(prog1[k]));
            chk("b2b_done",  32'(bus.done_o), 32'd0);
            step();
        end
        chk("b2b_done_end", 32'(bus.done_o), 32'd1);
        chk("b2b_overrun",  32'(bus.overrun_o), 32'd0);
        step();
        chk("b2b_hold_instr", 32'(bus.instr_o), 32'h03);
        chk_idle_outputs("b2b_idle");

        // ---- overrun: pixel_start 3 cycles into a run
        bus.pixel_start_i = 1'b1;
        step();
        bus.pixel_start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("ovr_exec",  32'(bus.execute_o), 32'd1);
            chk("ovr_instr", 32'(bus.instr_o), 32'(prog1[k]));
            bus.pixel_start_i = (k == 2);
            step();
            bus.pixel_start_i = 1'b0;
        end
        chk("ovr_done",    32'(bus.done_o), 32'd1);
        chk("ovr_flag",    32'(bus.overrun_o), 32'd1);
        step();
        step();
        chk("ovr_sticky",  32'(bus.overrun_o), 32'd1);
        chk_idle_outputs("ovr_idle");

        // ---- load_start at the 4th issue aborts the run
        bus.pixel_start_i = 1'b1;
        step();
        bus.pixel_start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("abt_instr", 32'(bus.instr_o), 32'(prog1[k]));
            if (k == 3) bus.load_start_i = 1'b1;
            step();
        end
        bus.load_start_i = 1'b0;
        chk("abt_exec",    32'(bus.execute_o), 32'd0);
        chk("abt_done",    32'(bus.done_o), 32'd0);
        chk("abt_ready",   32'(bus.load_ready_o), 32'd1);
        chk("abt_overrun", 32'(bus.overrun_o), 32'd0);
        // pixel_start inside LOAD is ignored, no overrun
        bus.pixel_start_i = 1'b1;
        step();
        bus.pixel_start_i = 1'b0;
        chk("ld_pix_ready",   32'(bus.load_ready_o), 32'd1);
        chk("ld_pix_overrun", 32'(bus.overrun_o), 32'd0);
        chk_idle_outputs("ld_pix");
        step();
        chk_idle_outputs("ld_pix_late");
        for (int i = 0; i < 8; i++) begin
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = prog2[i];
            step();
        end
        bus.load_valid_i = 1'b0;
        chk("ld2_ready_end", 32'(bus.load_ready_o), 32'd0);

        // ---- simultaneous load_start and pixel_start in IDLE: LOAD only
        bus.load_start_i  = 1'b1;
        bus.pixel_start_i = 1'b1;
        step();
        bus.load_start_i  = 1'b0;
        bus.pixel_start_i = 1'b0;
        chk("sim_ready", 32'(bus.load_ready_o), 32'd1);
        chk_idle_outputs("sim");
        step();
        chk_idle_outputs("sim_late");
        for (int i = 0; i < 8; i++) begin
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = prog2[i];
            step();
        end
        bus.load_valid_i = 1'b0;
        chk("ld3_ready_end", 32'(bus.load_ready_o), 32'd0);

        // ---- reset mid-run (with overrun set)
        bus.pixel_start_i = 1'b1;
        step();
        bus.pixel_start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mr_instr", 32'(bus.instr_o), 32'(prog2[k]));
            bus.pixel_start_i = (k == 0);
            step();
            bus.pixel_start_i = 1'b0;
        end
        chk("mr_overrun_pre", 32'(bus.overrun_o), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_instr_rst",   32'(bus.instr_o), 32'h30);
        chk("mr_exec_rst",    32'(bus.execute_o), 32'd0);
        chk("mr_done_rst",    32'(bus.done_o), 32'd0);
        chk("mr_overrun_rst", 32'(bus.overrun_o), 32'd0);
        chk("mr_ready_rst",   32'(bus.load_ready_o), 32'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            chk_idle_outputs("mr_quiet");
        end
        // memory was refilled with NOPs
        bus.pixel_start_i = 1'b1;
        step();
        bus.pixel_start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("mr_nop_exec",  32'(bus.execute_o), 32'd1);
            chk("mr_nop_instr", 32'(bus.instr_o), 32'h30);
            step();
        end
        chk("mr_nop_done", 32'(bus.done_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_shader_sequencer
`default_nettype wire
